register_file_mp: RTL and testbench

Parametrised multi-port integer register file for the core's decode/writeback stages. It provides two combinational read ports, two write ports with fixed priority, and an optional hardwired zero register. It also supports write-to-read bypass, a per-register pending scoreboard, and a sequential post-reset clear sequence, so the storage array needs no reset.

---
 rtl/register_file_mp.sv | 122 ++++++++++++
 tb/tb_register_file_mp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Multi-port integer register file: 2 combinational reads, 2 prioritised writes, pending scoreboard.
// Latency: reads are zero-latency (optional same-cycle write bypass); writes/scoreboard update on the rising edge.
// Backpressure: none; after reset a NREGS-cycle clear sequence runs (init_busy) and all requests are ignored.
module register_file_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [$clog2(NREGS)-1:0] wa0,
  input  logic [XLEN-1:0]          wd0,
  input  logic                     we1,
  input  logic [$clog2(NREGS)-1:0] wa1,
  input  logic [XLEN-1:0]          wd1,
  input  logic [$clog2(NREGS)-1:0] ra1,
  input  logic [$clog2(NREGS)-1:0] ra2,
  output logic [XLEN-1:0]          rd1,
  output logic [XLEN-1:0]          rd2,
  input  logic                     alloc_en,
  input  logic [$clog2(NREGS)-1:0] alloc_addr,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     init_busy
);

  localparam int AW = $clog2(NREGS);

  typedef enum logic {INIT, RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     w_cnt_nxt;
  logic [NREGS-1:0]  r_pend;
  logic [XLEN-1:0]   r_mem [NREGS];
  logic              w_run;
  logic              w_we0;
  logic              w_we1;

  assign w_run = (r_state == RUN);
  // Effective write strobes: nothing lands during the clear sequence, and register 0 drops writes when hardwired.
  assign w_we0 = w_run && we0 && !(ZERO_REG && (wa0 == '0));
  assign w_we1 = w_run && we1 && !(ZERO_REG && (wa1 == '0));

  // State and clear-counter registers; rst is the only reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: walk the counter across every register once, then enter RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW'(NREGS - 1)) begin
          w_state_nxt = RUN;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Storage array (no reset): zero-fill during INIT, otherwise port 1 overrides port 0 by coming last.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_we0) r_mem[wa0] <= wd0;
      if (w_we1) r_mem[wa1] <= wd1;
    end
  end

  // Pending scoreboard: writeback clears, allocation sets and wins on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NREGS; i++) begin
        if ((we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)))) r_pend[i] <= 1'b0;
        if (alloc_en && (alloc_addr == AW'(i)))                   r_pend[i] <= 1'b1;
      end
      if (ZERO_REG) r_pend[0] <= 1'b0;
    end
  end

  // Read port 1: array value, optionally forwarded from this cycle's writes, zero rule last.
  always_comb begin
    rd1 = r_mem[ra1];
    if (BYPASS) begin
      if (w_we0 && (wa0 == ra1)) rd1 = wd0;
      if (w_we1 && (wa1 == ra1)) rd1 = wd1;
    end
    if (!w_run || (ZERO_REG && (ra1 == '0))) rd1 = '0;
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    rd2 = r_mem[ra2];
    if (BYPASS) begin
      if (w_we0 && (wa0 == ra2)) rd2 = wd0;
      if (w_we1 && (wa1 == ra2)) rd2 = wd1;
    end
    if (!w_run || (ZERO_REG && (ra2 == '0))) rd2 = '0;
  end

  assign busy1     = w_run && r_pend[ra1];
  assign busy2     = w_run && r_pend[ra2];
  assign init_busy = !w_run;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: one instance with bypass, one without, sharing stimulus.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, alloc_en;
  logic [4:0]  wa0, wa1, ra1, ra2, alloc_addr;
  logic [31:0] wd0, wd1;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, init_busy_a;
  logic        busy1_b, busy2_b, init_busy_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  register_file_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(busy1_a), .busy2(busy2_a), .init_busy(init_busy_a)
  );

  register_file_mp #(.XLEN(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .busy1(busy1_b), .busy2(busy2_b), .init_busy(init_busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0;
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release reset and check the clear sequence is exactly 32 cycles, with requests ignored.
  task automatic run_init(input string tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      we0 = 1'b1; wa0 = 5'd31; wd0 = 32'h55;
      alloc_en = 1'b1; alloc_addr = 5'd31;
      ra1 = 5'(c); ra2 = 5'(31 - c);
      #1;
      chkb({tag, "_init_busy"}, init_busy_a, 1'b1);
      chk({tag, "_init_rd1"}, rd1_a, 32'h0);
      chkb({tag, "_init_busy1"}, busy1_a, 1'b0);
      tick();
    end
    idle();
    #1;
    chkb({tag, "_init_done"}, init_busy_a, 1'b0);
    chkb({tag, "_init_done_b"}, init_busy_b, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; ra1 = '0; ra2 = '0; alloc_addr = '0;
    #1;
    chkb("rst_init_busy", init_busy_a, 1'b1);
    chkb("rst_busy1", busy1_a, 1'b0);
    chk("rst_rd1", rd1_a, 32'h0);
    repeat (2) @(posedge clk);
    run_init("first");

    // Every register cleared, including 31 which was written during INIT.
    for (int r = 0; r < 32; r++) begin
      ra1 = 5'(r); ra2 = 5'(r);
      #1;
      chk("clr_rd1", rd1_a, 32'h0);
      chk("clr_rd2_b", rd2_b, 32'h0);
      chkb("clr_busy1", busy1_a, 1'b0);
    end

    // Basic write then read, with and without bypass.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
    #1;
    chk("wr5_bypass", rd1_a, 32'hDEADBEEF);
    chk("wr5_nobypass", rd1_b, 32'h0);
    tick();
    idle();
    #1;
    chk("rd5_a", rd1_a, 32'hDEADBEEF);
    chk("rd5_b", rd1_b, 32'hDEADBEEF);

    // Register 0 ignores writes even through the bypass path.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra2 = 5'd0;
    #1;
    chk("wr0_bypass", rd2_a, 32'h0);
    tick();
    idle();
    #1;
    chk("rd0_a", rd2_a, 32'h0);
    chk("rd0_b", rd2_b, 32'h0);

    // Two writes to one address: port 1 wins.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra1 = 5'd7;
    #1;
    chk("conf_bypass", rd1_a, 32'h22);
    chk("conf_nobypass", rd1_b, 32'h0);
    tick();
    idle();
    #1;
    chk("conf_after_a", rd1_a, 32'h22);
    chk("conf_after_b", rd1_b, 32'h22);

    // Port 0 alone, different ports on different addresses in one cycle.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h33;
    we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h44; ra2 = 5'd8;
    #1;
    chk("p0_bypass", rd1_a, 32'h33);
    chk("p0_nobypass", rd1_b, 32'h22);
    chk("p1_bypass_rd2", rd2_a, 32'h44);
    tick();
    idle();
    #1;
    chk("p0_after", rd1_b, 32'h33);
    chk("p1_after", rd2_b, 32'h44);

    // Scoreboard: allocate 9, no same-cycle visibility.
    alloc_en = 1'b1; alloc_addr = 5'd9; ra1 = 5'd9;
    #1;
    chkb("alloc_same_cycle", busy1_a, 1'b0);
    tick();
    idle();
    #1;
    chkb("alloc_next", busy1_a, 1'b1);
    // Clear and set together: set wins.
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99; alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    idle();
    #1;
    chkb("set_wins", busy1_a, 1'b1);
    // Writeback alone clears, visible next cycle.
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h9A;
    #1;
    chkb("clr_same_cycle", busy1_a, 1'b1);
    tick();
    idle();
    #1;
    chkb("clr_next", busy1_a, 1'b0);
    // Port 1 also clears.
    alloc_en = 1'b1; alloc_addr = 5'd12; ra2 = 5'd12;
    tick();
    idle();
    #1;
    chkb("alloc12", busy2_a, 1'b1);
    we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h12;
    tick();
    idle();
    #1;
    chkb("clr12_p1", busy2_a, 1'b0);
    // Register 0 is never pending.
    alloc_en = 1'b1; alloc_addr = 5'd0; ra2 = 5'd0;
    tick();
    idle();
    #1;
    chkb("alloc0", busy2_a, 1'b0);

    // Reset during RUN.
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA; alloc_en = 1'b1; alloc_addr = 5'd3; ra1 = 5'd3;
    tick();
    idle();
    #1;
    chk("r3_written", rd1_a, 32'hAA);
    chkb("r3_pending", busy1_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chkb("arst_busy1", busy1_a, 1'b0);
    chkb("arst_init_busy", init_busy_a, 1'b1);
    chk("arst_rd1", rd1_a, 32'h0);
    run_init("second");
    ra1 = 5'd3; ra2 = 5'd31;
    #1;
    chk("r3_cleared", rd1_a, 32'h0);
    chk("r3_cleared_b", rd1_b, 32'h0);
    chkb("r3_not_pending", busy1_a, 1'b0);
    chk("r31_cleared", rd2_a, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
